// File: rtl/mac_operand_queue.sv
// -----------------------------------------------------------------------------
// mac_operand_queue
//   Four-entry circular queue carrying MAC operand pairs (A, B) from operand
//   fetch to the MAC datapath. The queue owns the tail pointer TP, head
//   pointer HP and wrap flag Round. The downstream per-entry ready-mask logic
//   derives entry validity from these three signals.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   push handshake (in_ready = !Full)
//   in_a, in_b          operand pair to push
//   out_valid/out_ready pop handshake (out_valid = !Empty)
//   out_a, out_b        operand pair at HP, combinational read of storage
//   TP, HP, Round       pointer state exported to the ready-mask logic
//   Count               occupancy, 0..BufferSize
//   Full, Empty         occupancy flags
//
// Optional feature (macro MAC_QUEUE_HWM_EN)
//   hwm_clear  input   loads HighWater with the current Count (has priority)
//   HighWater  output  peak occupancy since reset or since the last clear
// -----------------------------------------------------------------------------
module mac_operand_queue #(
  parameter int DataWidth         = 8,
  parameter int BufferWidth       = 2,
  parameter int BufferSize        = 4,
  parameter int PseudoBufferWidth = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DataWidth-1:0]         in_a,
  input  logic [DataWidth-1:0]         in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DataWidth-1:0]         out_a,
  output logic [DataWidth-1:0]         out_b,
  output logic [BufferWidth-1:0]       TP,
  output logic [BufferWidth-1:0]       HP,
  output logic                         Round,
  output logic [PseudoBufferWidth-1:0] Count,
  output logic                         Full,
  output logic                         Empty
`ifdef MAC_QUEUE_HWM_EN
  ,
  input  logic                         hwm_clear,
  output logic [PseudoBufferWidth-1:0] HighWater
`endif
);

  localparam logic [BufferWidth-1:0] LastSlot = BufferWidth'(BufferSize - 1);

  logic [BufferWidth-1:0] r_tp;
  logic [BufferWidth-1:0] r_hp;
  logic                   r_round;
  logic [2*DataWidth-1:0] r_mem [BufferSize];

  logic                         w_ptr_eq;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_tp_wrap;
  logic                         w_hp_wrap;
  logic [BufferWidth-1:0]       w_tp_next;
  logic [BufferWidth-1:0]       w_hp_next;
  logic                         w_round_next;
  logic [PseudoBufferWidth-1:0] w_count;
  logic [2*DataWidth-1:0]       w_head;

  // Round distinguishes full from empty when the pointers coincide.
  assign w_ptr_eq = (r_tp == r_hp);
  assign w_full   = r_round & w_ptr_eq;
  assign w_empty  = ~r_round & w_ptr_eq;

  assign w_push = in_valid & ~w_full;
  assign w_pop  = out_ready & ~w_empty;

  assign w_tp_wrap = w_push & (r_tp == LastSlot);
  assign w_hp_wrap = w_pop & (r_hp == LastSlot);

  // Pointers are exactly log2(BufferSize) bits wide, so +1 wraps by itself.
  assign w_tp_next = w_push ? r_tp + 1'b1 : r_tp;
  assign w_hp_next = w_pop  ? r_hp + 1'b1 : r_hp;
  // Each wrap toggles Round; two wraps on one edge cancel out.
  assign w_round_next = r_round ^ w_tp_wrap ^ w_hp_wrap;

  // {Round,TP} is a virtual tail over twice the buffer; subtracting HP yields
  // the occupancy directly.
  assign w_count = PseudoBufferWidth'({r_round, r_tp} - {1'b0, r_hp});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp    <= '0;
      r_hp    <= '0;
      r_round <= 1'b0;
    end else begin
      r_tp    <= w_tp_next;
      r_hp    <= w_hp_next;
      r_round <= w_round_next;
    end
  end

  // Storage is intentionally left out of reset; contents behind HP are dead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tp] <= {in_a, in_b};
    end
  end

  assign w_head = r_mem[r_hp];

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_a     = w_head[2*DataWidth-1:DataWidth];
  assign out_b     = w_head[DataWidth-1:0];
  assign TP        = r_tp;
  assign HP        = r_hp;
  assign Round     = r_round;
  assign Count     = w_count;
  assign Full      = w_full;
  assign Empty     = w_empty;

`ifdef MAC_QUEUE_HWM_EN
  logic [PseudoBufferWidth-1:0] r_high_water;
  logic [PseudoBufferWidth-1:0] w_count_next;

  // Track against the occupancy the queue is about to have after this edge.
  assign w_count_next = PseudoBufferWidth'({w_round_next, w_tp_next} - {1'b0, w_hp_next});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_water <= '0;
    end else if (hwm_clear) begin
      r_high_water <= w_count;
    end else if (w_count_next > r_high_water) begin
      r_high_water <= w_count_next;
    end
  end

  assign HighWater = r_high_water;
`endif

endmodule

// File: tb/tb_mac_operand_queue.sv
module tb_mac_operand_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [1:0] TP;
  logic [1:0] HP;
  logic       Round;
  logic [2:0] Count;
  logic       Full;
  logic       Empty;
`ifdef MAC_QUEUE_HWM_EN
  logic       hwm_clear;
  logic [2:0] HighWater;
`endif

  always #5 clk = ~clk;

  mac_operand_queue #(
    .DataWidth(8), .BufferWidth(2), .BufferSize(4), .PseudoBufferWidth(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .TP(TP), .HP(HP), .Round(Round), .Count(Count), .Full(Full), .Empty(Empty)
`ifdef MAC_QUEUE_HWM_EN
    , .hwm_clear(hwm_clear), .HighWater(HighWater)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the pointer state plus a scoreboard of queued pairs.
  logic [15:0] sb[$];
  int m_tp = 0, m_hp = 0, m_round = 0, m_count = 0, m_hw = 0;

  task automatic model_reset();
    m_tp = 0; m_hp = 0; m_round = 0; m_count = 0; m_hw = 0;
    sb.delete();
  endtask

  // Advance one clock edge, updating the model from the driven inputs.
  task automatic tick();
    bit push, pop;
    int old_count;
    logic [15:0] tmp;
    push = in_valid && (m_count != 4);
    pop  = out_ready && (m_count != 0);
    old_count = m_count;
    if (push) begin
      sb.push_back({in_a, in_b});
      if (m_tp == 3) m_round ^= 1;
      m_tp = (m_tp + 1) % 4;
    end
    if (pop) begin
      tmp = sb.pop_front();
      if (m_hp == 3) m_round ^= 1;
      m_hp = (m_hp + 1) % 4;
    end
    m_count = m_round * 4 + m_tp - m_hp;
`ifdef MAC_QUEUE_HWM_EN
    if (hwm_clear) m_hw = old_count;
    else if (m_count > m_hw) m_hw = m_count;
`endif
    $display("t=%0t push=%0b a=%0d b=%0d pop=%0b count=%0d", $time, push, in_a, in_b, pop, m_count);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (TP !== 2'd0 || HP !== 2'd0 || Round !== 1'b0 || Count !== 3'd0 ||
        Empty !== 1'b1 || Full !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: TP=%0d HP=%0d Round=%0b Count=%0d Empty=%0b Full=%0b in_ready=%0b out_valid=%0b, required 0 0 0 0 1 0 1 0",
               TP, HP, Round, Count, Empty, Full, in_ready, out_valid);
    end
    in_valid = 1'b1; in_a = 8'hA1; in_b = 8'hB1; tick();
    in_a = 8'hA2; in_b = 8'hB2; tick();
    in_valid = 1'b0;
    vectors++;
    if (Count !== 3'd2 || TP !== 2'd2) begin
      miscompares++;
      $display("FAIL reset_preload: Count=%0d TP=%0d, required 2 2", Count, TP);
    end
    // Assert reset between edges; pointers must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (TP !== 2'd0 || HP !== 2'd0 || Round !== 1'b0 || Count !== 3'd0 ||
        Empty !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: TP=%0d HP=%0d Round=%0b Count=%0d Empty=%0b in_ready=%0b, required 0 0 0 0 1 1",
               TP, HP, Round, Count, Empty, in_ready);
    end
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (Count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: Count=%0d out_valid=%0b, required 0 0", Count, out_valid);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'(2 * i + 1); in_b = 8'(2 * i + 2);
      tick();
      vectors++;
      if (Count !== 3'(m_count) || TP !== 2'(m_tp)) begin
        miscompares++;
        $display("FAIL fill_step%0d: Count=%0d TP=%0d, required %0d %0d", i, Count, TP, m_count, m_tp);
      end
    end
    vectors++;
    if (TP !== 2'd0 || Round !== 1'b1 || Full !== 1'b1 || in_ready !== 1'b0 || Count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_full: TP=%0d Round=%0b Full=%0b in_ready=%0b Count=%0d, required 0 1 1 0 4",
               TP, Round, Full, in_ready, Count);
    end
    in_a = 8'd9; in_b = 8'd10;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (Count !== 3'd4 || TP !== 2'd0 || HP !== 2'd0) begin
      miscompares++;
      $display("FAIL fill_reject: Count=%0d TP=%0d HP=%0d, required 4 0 0", Count, TP, HP);
    end
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || {out_a, out_b} !== sb[0]) begin
        miscompares++;
        $display("FAIL drain_data%0d: out_valid=%0b a=%0d b=%0d, required 1 %0d %0d",
                 i, out_valid, out_a, out_b, sb[0][15:8], sb[0][7:0]);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (HP !== 2'd0 || Round !== 1'b0 || Empty !== 1'b1 || Count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_empty: HP=%0d Round=%0b Empty=%0b Count=%0d, required 0 0 1 0", HP, Round, Empty, Count);
    end
  endtask

  task automatic test_wrap_concurrent();
    // Bring the queue to HP=0 with three entries (TP=3).
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(8'h20 + i); in_b = 8'(8'h30 + i);
      tick();
    end
    vectors++;
    if (TP !== 2'd3 || HP !== 2'd0 || Count !== 3'd3) begin
      miscompares++;
      $display("FAIL wrap_preload: TP=%0d HP=%0d Count=%0d, required 3 0 3", TP, HP, Count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
      vectors++;
      if ({out_a, out_b} !== sb[0]) begin
        miscompares++;
        $display("FAIL wrap_data%0d: a=%0d b=%0d, required %0d %0d", i, out_a, out_b, sb[0][15:8], sb[0][7:0]);
      end
      tick();
      vectors++;
      if (Count !== 3'd3 || TP !== 2'(m_tp) || HP !== 2'(m_hp) || Round !== m_round[0]) begin
        miscompares++;
        $display("FAIL wrap_state%0d: Count=%0d TP=%0d HP=%0d Round=%0b, required 3 %0d %0d %0b",
                 i, Count, TP, HP, Round, m_tp, m_hp, m_round[0]);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({out_a, out_b} !== sb[0]) begin
        miscompares++;
        $display("FAIL wrap_tail%0d: a=%0d b=%0d, required %0d %0d", i, out_a, out_b, sb[0][15:8], sb[0][7:0]);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_end: Empty=%0b, required 1", Empty);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'(8'h40 + i); in_b = 8'(8'h50 + i);
      tick();
    end
    // Full with both handshakes offered: only the pop may happen.
    in_a = 8'h77; in_b = 8'h88;
    out_ready = 1'b1;
    vectors++;
    if (Full !== 1'b1 || {out_a, out_b} !== sb[0]) begin
      miscompares++;
      $display("FAIL fullpop_head: Full=%0b a=%0d b=%0d, required 1 %0d %0d", Full, out_a, out_b, sb[0][15:8], sb[0][7:0]);
    end
    tick();
    vectors++;
    if (Count !== 3'd3 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_count: Count=%0d in_ready=%0b, required 3 1", Count, in_ready);
    end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (Count !== 3'd4 || Full !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_retry: Count=%0d Full=%0b, required 4 1", Count, Full);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({out_a, out_b} !== sb[0]) begin
        miscompares++;
        $display("FAIL fullpop_drain%0d: a=%0d b=%0d, required %0d %0d", i, out_a, out_b, sb[0][15:8], sb[0][7:0]);
      end
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_end: Empty=%0b, required 1", Empty);
    end
  endtask

`ifdef MAC_QUEUE_HWM_EN
  task automatic test_hwm();
    hwm_clear = 1'b1; tick(); hwm_clear = 1'b0;
    vectors++;
    if (HighWater !== 3'd0) begin
      miscompares++;
      $display("FAIL hwm_zero: HighWater=%0d, required 0", HighWater);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(i); in_b = 8'(i); tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    vectors++;
    if (HighWater !== 3'd3 || Count !== 3'd1 || HighWater !== 3'(m_hw)) begin
      miscompares++;
      $display("FAIL hwm_peak: HighWater=%0d Count=%0d, required 3 1", HighWater, Count);
    end
    hwm_clear = 1'b1; tick(); hwm_clear = 1'b0;
    vectors++;
    if (HighWater !== 3'd1) begin
      miscompares++;
      $display("FAIL hwm_clear: HighWater=%0d, required 1", HighWater);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
`ifdef MAC_QUEUE_HWM_EN
    hwm_clear = 1'b0;
`endif
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap_concurrent();
    test_full_pop();
`ifdef MAC_QUEUE_HWM_EN
    test_hwm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
